diskemu_xfer: RTL and testbench
===============================

# diskemu_xfer

Arduino-side EEPROM transfer sequencer for the disk emulator CPLD. It accepts single-byte read/write commands from the Arduino port logic and arbitrates for the shared bus with `busreq`. It then generates correctly timed address setup, `ard_een`/`ard_rw` strobes and the EEPROM write-cycle wait. It sits directly upstream of the bus-flow/bank glue, which consumes `busreq`, `ard_rw`, `ard_een` and returns the bus grant.

## Interface
Parameters:
- `SETUP_CYC`, 2: address/data setup cycles before a strobe.
- `PULSE_CYC`, 4: strobe low width in cycles.
- `TWC_CYC`, 80000: EEPROM write-cycle wait (10 ms at 8 MHz).
- `GRANT_CYC`, 64: maximum cycles to wait for grant.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  command strobe, sampled only in IDLE.
- `wr`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  15  EEPROM address; [14:13] is bank, captured with `req`.
- `wdata`  in  8  write data, captured with `req`.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`: grant timeout, grant loss or poll timeout.
- `busy`  out  1  high outside IDLE.
- `rdata`  out  8  read data, held until the next read completes.
- `busreq`  out  1  bus request to glue.
- `grant`  in  1  Arduino is bus master (glue's `ard_busmaster`).
- `ard_rw`  out  1  EEPROM write enable, active-low.
- `ard_een`  out  1  EEPROM output enable, active-low.
- `a_addr`  out  15  address driven while master.
- `d_out`  out  8  write data.
- `d_oe`  out  1  data bus drive enable.
- `d_in`  in  8  data bus sample.

## Operation
- States: IDLE → REQ → SETUP → STROBE → HOLD → (WAIT if write) → DONE → IDLE.
- IDLE: outputs inactive. `req`=1 latches `wr`/`addr`/`wdata` and moves to REQ. `req` in any other state is ignored.
- REQ: `busreq`=1. Moves to SETUP on `grant`=1. After GRANT_CYC cycles without grant, goes to DONE with err.
- SETUP: `a_addr` driven; `d_oe`=wr. Lasts SETUP_CYC cycles.
- STROBE: `ard_rw`=0 for a write or `ard_een`=0 for a read, for PULSE_CYC cycles. A read latches `d_in` into `rdata` on the last STROBE edge.
- HOLD: 1 cycle. Strobes are high; address and data are still driven.
- WAIT: `d_oe`=0 and strobes are high. `busreq` is held so the CoCo cannot read a busy part. Lasts TWC_CYC cycles.
- DONE: `ack`=1 for 1 cycle, `busreq`=0, return to IDLE.
- `grant` falling in SETUP/STROBE/HOLD/WAIT: strobes and `d_oe` deassert in the same cycle (combinational on grant). Next state is DONE with err. `rdata` is unchanged.
- Reset values: `ack`=0, `err`=0, `busy`=0, `busreq`=0, `ard_rw`=1, `ard_een`=1, `d_oe`=0, `rdata`=0, `a_addr`=0, `d_out`=0.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values. A truncated write is not retried.
- `ard_rw` and `ard_een` are never low in the same cycle.
- Counter width is clog2 of the largest parameter. Counters load at state entry and count down to 0, with no wrap.

## Timing
- Cycle numbering: `req` is sampled at edge 0. REQ occupies cycle 1.
- With `grant` already high:
  - SETUP: cycles 2..1+S.
  - STROBE: cycles 2+S..1+S+P.
  - HOLD: cycle 2+S+P.
- Read: `ack` in cycle 3+S+P (cycle 9 at defaults).
- Write: `ack` in cycle 3+S+P+TWC_CYC.
- Each grant-wait cycle adds one cycle to these latencies.
- `busy` rises in cycle 1 and falls with `ack`.
- Back-to-back: the earliest next `req` accepted is the cycle after `ack`.

## Configuration
- `DISKEMU_DATA_POLL_EN` defined: WAIT performs repeated reads of the latched address (SETUP_CYC setup plus PULSE_CYC `ard_een` low each). WAIT ends when `d_in[7]`==`wdata[7]`. After TWC_CYC total cycles it ends with err. Write latency becomes variable.
- `DISKEMU_DATA_POLL_EN` undefined: WAIT is a fixed TWC_CYC countdown with no reads.

## Structure
- `diskemu_pkg`: state enum, default timing constants, command struct (wr, addr, wdata).
- Sub-module `diskemu_cnt`: loadable down-counter with a zero flag, shared by grant, setup, pulse and write-cycle timing.

## Test plan
- Read: `grant` tied high, addr=0x6001, `d_in`=0xA5.
  - Expect `ard_een` low in cycles 4–7 and `ard_rw` high throughout.
  - Expect `ack` in cycle 9, `rdata`=0xA5, `err`=0.
- Write, poll off, TWC_CYC=100: wdata=0x3C.
  - Expect `ard_rw` low for 4 cycles, `d_oe` high in SETUP through HOLD.
  - Expect `ack` in cycle 109 with `busreq` held until then.
- Grant timeout: `grant`=0 throughout → `ack`=1 with `err`=1 at cycle 65; `ard_rw` and `ard_een` never low.
- Grant drop in STROBE of a write: `ard_rw` high in the same cycle, then `ack`+`err` in the next cycle; the next `req` is accepted.
- Reset in WAIT: assert `reset` for 1 cycle → next cycle all outputs at reset values, `busy`=0.
- Poll on: wdata[7]=1 and `d_in[7]`=0 for 3 polls, then 1.
  - Expect exactly 4 `ard_een` pulses, then `ack` with `err`=0.
  - With `d_in[7]` stuck at 0: `err`=1 at TWC_CYC.

Source files
------------

// File: rtl/diskemu_pkg.sv
// Shared types and default timing for the disk emulator EEPROM transfer sequencer.
package diskemu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StSetup,
        StStrobe,
        StHold,
        StWait,
        StDone
    } state_e;

    localparam int unsigned SetupCycDef = 2;
    localparam int unsigned PulseCycDef = 4;
    localparam int unsigned TwcCycDef   = 80000;
    localparam int unsigned GrantCycDef = 64;

    typedef struct packed {
        logic        wr;
        logic [14:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    // Counter width sized to the largest timing parameter.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b,
                                              int unsigned c, int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 32'd1 : int'($clog2(m));
    endfunction

endpackage

// File: rtl/diskemu_xfer_if.sv
// Command port from the Arduino logic plus the EEPROM/bus-glue signals of the transfer sequencer.
interface diskemu_xfer_if;
    logic        req;
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic [7:0]  rdata;
    logic        busreq;
    logic        grant;
    logic        ard_rw;
    logic        ard_een;
    logic [14:0] a_addr;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;

    modport slave (
        input  req, wr, addr, wdata, grant, d_in,
        output ack, err, busy, rdata, busreq, ard_rw, ard_een, a_addr, d_out, d_oe
    );

    modport master (
        output req, wr, addr, wdata, grant, d_in,
        input  ack, err, busy, rdata, busreq, ard_rw, ard_een, a_addr, d_out, d_oe
    );
endinterface

// File: rtl/diskemu_cnt.sv
// Loadable down-counter that stops at zero; zero_o flags the terminal count.
module diskemu_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);
    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/diskemu_xfer.sv
// Arduino-side EEPROM single-byte transfer sequencer: bus request, setup, strobe, write-cycle wait.
// Define DISKEMU_DATA_POLL_EN to replace the fixed write-cycle wait with bit-7 data polling.
module diskemu_xfer
    import diskemu_pkg::*;
#(
    parameter int unsigned SETUP_CYC = SetupCycDef,
    parameter int unsigned PULSE_CYC = PulseCycDef,
    parameter int unsigned TWC_CYC   = TwcCycDef,
    parameter int unsigned GRANT_CYC = GrantCycDef
) (
    input logic           clk,
    input logic           reset,
    diskemu_xfer_if.slave bus
);
    localparam int unsigned CntW = cnt_width(SETUP_CYC, PULSE_CYC, TWC_CYC, GRANT_CYC);
    localparam logic [CntW-1:0] GrantLd = CntW'(GRANT_CYC - 1);
    localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] TwcLd   = CntW'(TWC_CYC - 1);

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d, ack_q, ack_d, busy_q, busy_d, busreq_q, busreq_d;
    logic        een_q, een_d, rw_q, rw_d, doe_q, doe_d;
    logic [14:0] a_addr_q, a_addr_d;
    logic [7:0]  d_out_q, d_out_d;
    logic            cnt_load, cnt_zero;
    logic [CntW-1:0] cnt_val;

    diskemu_cnt #(.Width(CntW)) u_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

`ifdef DISKEMU_DATA_POLL_EN
    // The phase counter times each poll; this one bounds the whole wait.
    logic poll_str_q, poll_str_d, tw_load, tw_zero;

    diskemu_cnt #(.Width(CntW)) u_tw_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tw_load),
        .load_val_i (TwcLd),
        .zero_o     (tw_zero)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = SetupLd;
`ifdef DISKEMU_DATA_POLL_EN
        poll_str_d = poll_str_q;
        tw_load    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    cmd_d.wr    = bus.wr;
                    cmd_d.addr  = bus.addr;
                    cmd_d.wdata = bus.wdata;
                    state_d     = StReq;
                    cnt_load    = 1'b1;
                    cnt_val     = GrantLd;
                end
            end
            StReq: begin
                if (bus.grant) begin
                    state_d  = StSetup;
                    cnt_load = 1'b1;
                    cnt_val  = SetupLd;
                end else if (cnt_zero) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StSetup: begin
                if (!bus.grant) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (cnt_zero) begin
                    state_d  = StStrobe;
                    cnt_load = 1'b1;
                    cnt_val  = PulseLd;
                end
            end
            StStrobe: begin
                if (!bus.grant) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (cnt_zero) begin
                    if (!cmd_q.wr) rdata_d = bus.d_in;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!bus.grant) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (cmd_q.wr) begin
                    state_d  = StWait;
                    cnt_load = 1'b1;
`ifdef DISKEMU_DATA_POLL_EN
                    cnt_val    = SetupLd;
                    poll_str_d = 1'b0;
                    tw_load    = 1'b1;
`else
                    cnt_val  = TwcLd;
`endif
                end else begin
                    state_d = StDone;
                end
            end
            StWait: begin
                if (!bus.grant) begin
                    state_d = StDone;
                    err_d   = 1'b1;
`ifdef DISKEMU_DATA_POLL_EN
                end else if (poll_str_q && cnt_zero && (bus.d_in[7] == cmd_q.wdata[7])) begin
                    state_d = StDone;
                end else if (tw_zero) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    cnt_val    = poll_str_q ? SetupLd : PulseLd;
                    poll_str_d = !poll_str_q;
                end
`else
                end else if (cnt_zero) begin
                    state_d = StDone;
                end
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        ack_d    = (state_d == StDone);
        busy_d   = (state_d != StIdle);
        busreq_d = state_d inside {StReq, StSetup, StStrobe, StHold, StWait};
        rw_d     = (state_d == StStrobe) && cmd_d.wr;
        een_d    = (state_d == StStrobe) && !cmd_d.wr;
`ifdef DISKEMU_DATA_POLL_EN
        een_d    = een_d || ((state_d == StWait) && poll_str_d);
`endif
        doe_d    = cmd_d.wr && (state_d inside {StSetup, StStrobe, StHold});
        a_addr_d = (state_d inside {StSetup, StStrobe, StHold, StWait}) ? cmd_d.addr : '0;
        d_out_d  = doe_d ? cmd_d.wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            busreq_q <= 1'b0;
            een_q    <= 1'b0;
            rw_q     <= 1'b0;
            doe_q    <= 1'b0;
            a_addr_q <= '0;
            d_out_q  <= '0;
`ifdef DISKEMU_DATA_POLL_EN
            poll_str_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            busreq_q <= busreq_d;
            een_q    <= een_d;
            rw_q     <= rw_d;
            doe_q    <= doe_d;
            a_addr_q <= a_addr_d;
            d_out_q  <= d_out_d;
`ifdef DISKEMU_DATA_POLL_EN
            poll_str_q <= poll_str_d;
`endif
        end
    end

    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.rdata  = rdata_q;
    assign bus.busreq = busreq_q;
    assign bus.a_addr = a_addr_q;
    assign bus.d_out  = d_out_q;
    // Losing the bus must release the strobes and data drive without waiting for an edge.
    assign bus.ard_rw  = ~(rw_q & bus.grant);
    assign bus.ard_een = ~(een_q & bus.grant);
    assign bus.d_oe    = doe_q & bus.grant;
endmodule

// File: tb/tb_diskemu_xfer.sv
// Bench for diskemu_xfer: table of transfers scored through an expected-result queue,
// plus hand-written grant-drop and reset-in-wait sequences.
module tb_diskemu_xfer;
    import diskemu_pkg::*;

    localparam int unsigned S   = 2;
    localparam int unsigned P   = 4;
    localparam int unsigned TWC = 100;
    localparam int unsigned G   = 64;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          gdly;   // grant low for this many REQ cycles; -1 = never granted
        int          flip;   // d_in[7] inverted until this ard_een pulse; 0 = never
        int          lat;
        logic        err;
        logic [7:0]  rdata;
        int          een;    // ard_een low cycles
        int          rw;     // ard_rw low cycles
        int          doe;    // d_oe high cycles
    } vec_t;

    typedef struct {
        int         lat;
        logic       err;
        logic [7:0] rdata;
        int         een;
        int         rw;
        int         doe;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_rdata = 8'h00;
    vec_t vecs[$];
    exp_t sb[$];

    diskemu_xfer_if bus ();

    diskemu_xfer #(
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .TWC_CYC   (TWC),
        .GRANT_CYC (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_busreq"}, 32'(bus.busreq), 0);
        chk({tag, "_ard_rw"}, 32'(bus.ard_rw), 1);
        chk({tag, "_ard_een"}, 32'(bus.ard_een), 1);
        chk({tag, "_d_oe"}, 32'(bus.d_oe), 0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 0);
        chk({tag, "_a_addr"}, 32'(bus.a_addr), 0);
        chk({tag, "_d_out"}, 32'(bus.d_out), 0);
    endtask

    function automatic vec_t mkv(logic wr, logic [14:0] addr, logic [7:0] wdata, logic [7:0] din,
                                 int gdly, int flip, int lat, logic err, logic [7:0] rdata,
                                 int een, int rw, int doe);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.din = din; v.gdly = gdly; v.flip = flip;
        v.lat = lat; v.err = err; v.rdata = rdata; v.een = een; v.rw = rw; v.doe = doe;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   een_n = 0, rw_n = 0, doe_n = 0, ovl = 0, pulses = 0;
        bit   done = 0, een_prev = 0, busreq_prev = 0;
        e.lat = v.lat; e.err = v.err; e.rdata = v.rdata;
        e.een = v.een; e.rw = v.rw; e.doe = v.doe;
        sb.push_back(e);
        bus.wr    = v.wr;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        bus.d_in  = (v.flip > 0) ? (v.din ^ 8'h80) : v.din;
        bus.grant = (v.gdly == 0);
        bus.req   = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        for (int c = 1; c <= 300 && !done; c++) begin
            if (v.gdly > 0 && c > v.gdly) bus.grant = 1'b1;
            #1;
            if (c == 1) chk("busy_rise", 32'(bus.busy), 1);
            if (v.gdly >= 0 && c == 2 + v.gdly) begin
                chk("a_addr_setup", 32'(bus.a_addr), 32'(v.addr));
                if (v.wr) chk("d_out_setup", 32'(bus.d_out), 32'(v.wdata));
            end
            if (!bus.ard_een) begin
                een_n++;
                if (!een_prev) pulses++;
            end
            een_prev = !bus.ard_een;
            if (v.flip > 0 && pulses >= v.flip) bus.d_in = v.din;
            if (!bus.ard_rw) rw_n++;
            if (bus.d_oe) doe_n++;
            if (!bus.ard_rw && !bus.ard_een) ovl++;
            if (bus.ack) begin
                done = 1;
                e = sb.pop_front();
                chk("ack_latency", 32'(c), 32'(e.lat));
                chk("err", 32'(bus.err), 32'(e.err));
                chk("rdata", 32'(bus.rdata), 32'(e.rdata));
                chk("een_low_cycles", 32'(een_n), 32'(e.een));
                chk("rw_low_cycles", 32'(rw_n), 32'(e.rw));
                chk("d_oe_cycles", 32'(doe_n), 32'(e.doe));
                chk("strobe_overlap", 32'(ovl), 0);
                chk("busreq_held", 32'(busreq_prev), 1);
                chk("busreq_drop", 32'(bus.busreq), 0);
            end
            busreq_prev = bus.busreq;
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack within 300 cycles, expected at %0d", v.lat);
            if (sb.size() > 0) void'(sb.pop_front());
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            #1;
            chk("busy_fall", 32'(bus.busy), 0);
        end
        last_rdata = v.rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.grant = 1'b0; bus.d_in = '0;

        vecs.push_back(mkv(0, 15'h6001, 8'h00, 8'hA5, 0, 0, 9, 0, 8'hA5, 4, 0, 0));
        vecs.push_back(mkv(0, 15'h1234, 8'h00, 8'h5A, 3, 0, 12, 0, 8'h5A, 4, 0, 0));
`ifdef DISKEMU_DATA_POLL_EN
        vecs.push_back(mkv(1, 15'h2000, 8'h3C, 8'h00, 0, 0, 15, 0, 8'h5A, 4, 4, 7));
`else
        vecs.push_back(mkv(1, 15'h2000, 8'h3C, 8'h00, 0, 0, 109, 0, 8'h5A, 0, 4, 7));
`endif
        vecs.push_back(mkv(0, 15'h0042, 8'h00, 8'hFF, -1, 0, 65, 1, 8'h5A, 0, 0, 0));
`ifdef DISKEMU_DATA_POLL_EN
        vecs.push_back(mkv(1, 15'h7FFF, 8'h81, 8'h80, 2, 4, 35, 0, 8'h5A, 16, 4, 7));
`else
        vecs.push_back(mkv(1, 15'h7FFF, 8'h81, 8'h80, 2, 4, 111, 0, 8'h5A, 0, 4, 7));
`endif
        vecs.push_back(mkv(0, 15'h4000, 8'h00, 8'h00, 0, 0, 9, 0, 8'h00, 4, 0, 0));
`ifdef DISKEMU_DATA_POLL_EN
        vecs.push_back(mkv(1, 15'h0123, 8'h80, 8'h00, 0, 0, 109, 1, 8'h00, 66, 4, 7));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Grant lost during the write strobe: strobe releases at once, error ack follows.
        bus.grant = 1'b1; bus.wr = 1'b1; bus.addr = 15'h1111; bus.wdata = 8'h55; bus.d_in = 8'h00;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("drop_rw_before", 32'(bus.ard_rw), 0);
        @(posedge clk); #1;
        bus.grant = 1'b0;
        #1;
        chk("drop_rw_same_cycle", 32'(bus.ard_rw), 1);
        chk("drop_d_oe_same_cycle", 32'(bus.d_oe), 0);
        chk("drop_een_same_cycle", 32'(bus.ard_een), 1);
        chk("drop_no_ack_yet", 32'(bus.ack), 0);
        @(posedge clk); #2;
        chk("drop_ack", 32'(bus.ack), 1);
        chk("drop_err", 32'(bus.err), 1);
        chk("drop_rdata_kept", 32'(bus.rdata), 32'(last_rdata));
        @(posedge clk); #1;
        run_vec(mkv(0, 15'h0555, 8'h00, 8'h96, 0, 0, 9, 0, 8'h96, 4, 0, 0));

        // Reset while the write cycle is being waited out.
        bus.grant = 1'b1; bus.wr = 1'b1; bus.addr = 15'h0321; bus.wdata = 8'h80; bus.d_in = 8'h00;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("wait_busreq_before_reset", 32'(bus.busreq), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("wait_reset");
        reset = 1'b0;
        last_rdata = 8'h00;
        @(posedge clk); #1;
        run_vec(mkv(0, 15'h0ABC, 8'h00, 8'hC3, 0, 0, 9, 0, 8'hC3, 4, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
